// File: rtl/byte_serializer.sv
// Byte-to-bit serializer: a byte accepted on edge N drives its first bit from N for CLKS_PER_BIT clocks.
// in_ready is high in IDLE and on the last clock of bit 7, so back-to-back bytes stream with no gap.
module byte_serializer #(
  parameter int CLKS_PER_BIT = 3,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       ser_last,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic            bit_end;
  logic            byte_end;
  logic            take;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    clk_cnt_d = clk_cnt_q;

    bit_end  = (clk_cnt_q == CNT_LAST);
    byte_end = (state_q == SHIFT) && (bit_cnt_q == 3'd7) && bit_end;
    // Gating with rst keeps in_ready low for the whole reset, not just after the flops clear.
    in_ready = !rst && ((state_q == IDLE) || byte_end);
    take     = in_valid && in_ready;

    if (take) begin
      shreg_d   = in_data;
      bit_cnt_d = 3'd0;
      clk_cnt_d = '0;
      state_d   = SHIFT;
    end else if (state_q == SHIFT) begin
      if (bit_end) begin
        clk_cnt_d = '0;
        shreg_d   = MSB_FIRST ? {shreg_q[6:0], 1'b0} : {1'b0, shreg_q[7:1]};
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_d = 3'd0;
          state_d   = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end else begin
        clk_cnt_d = clk_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      clk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      clk_cnt_q <= clk_cnt_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign ser_valid = (state_q == SHIFT);
  assign ser_last  = (state_q == SHIFT) && (bit_cnt_q == 3'd7);
  assign ser_out   = (state_q == SHIFT) && (MSB_FIRST ? shreg_q[7] : shreg_q[0]);

endmodule

// File: tb/tb_byte_serializer.sv
// Three serializer configurations checked against a queue-based bit-stream model.
module tb_byte_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] in_data   [3];
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic       ser_out   [3];
  logic       ser_valid [3];
  logic       ser_last  [3];
  logic       busy      [3];

  int checks = 0;
  int errors = 0;

  // expected {ser_out, ser_last} per ser_valid cycle
  logic [1:0]  expq [3][$];
  logic [63:0] cap_bits [3];
  int          cap_n [3];
  int          cap_l [3];

  byte_serializer #(.CLKS_PER_BIT(1), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .ser_out(ser_out[0]), .ser_valid(ser_valid[0]), .ser_last(ser_last[0]), .busy(busy[0]));
  byte_serializer #(.CLKS_PER_BIT(3), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .ser_out(ser_out[1]), .ser_valid(ser_valid[1]), .ser_last(ser_last[1]), .busy(busy[1]));
  byte_serializer #(.CLKS_PER_BIT(1), .MSB_FIRST(1'b1)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .ser_out(ser_out[2]), .ser_valid(ser_valid[2]), .ser_last(ser_last[2]), .busy(busy[2]));

  function automatic int cpb(int d);
    return (d == 1) ? 3 : 1;
  endfunction

  function automatic bit msbf(int d);
    return (d == 2);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor / scoreboard: samples on the falling edge, away from all input changes.
  initial begin
    for (int d = 0; d < 3; d++) begin
      cap_bits[d] = '0;
      cap_n[d]    = 0;
      cap_l[d]    = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          expq[d].delete();
          chk($sformatf("rst_outs%0d", d),
              {59'd0, in_ready[d], ser_out[d], ser_valid[d], ser_last[d], busy[d]}, 64'd0);
        end else begin
          automatic bit         exp_rdy = (expq[d].size() <= 1);
          automatic bit         exp_vld = (expq[d].size() > 0);
          automatic logic [1:0] e;
          chk($sformatf("in_ready%0d", d), 64'(in_ready[d]), 64'(exp_rdy));
          chk($sformatf("ser_valid%0d", d), 64'(ser_valid[d]), 64'(exp_vld));
          chk($sformatf("busy%0d", d), 64'(busy[d]), 64'(exp_vld));
          if (ser_valid[d]) begin
            cap_bits[d] = {cap_bits[d][62:0], ser_out[d]};
            cap_n[d]++;
            if (ser_last[d]) cap_l[d]++;
          end
          if (exp_vld) begin
            e = expq[d].pop_front();
            chk($sformatf("ser_out_last%0d", d), {62'd0, ser_out[d], ser_last[d]}, 64'(e));
          end
          if (in_valid[d] && exp_rdy) begin
            for (int i = 0; i < 8; i++) begin
              automatic logic b = msbf(d) ? in_data[d][7 - i] : in_data[d][i];
              for (int k = 0; k < cpb(d); k++) expq[d].push_back({b, (i == 7)});
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers byte b; returns 1ns after the accepting edge with in_valid still high.
  task automatic send(int d, logic [7:0] b, bit noise);
    for (int n = 0; n < 300; n++) begin
      if (in_ready[d]) begin
        in_valid[d] = 1'b1;
        in_data[d]  = b;
        step();
        return;
      end
      in_valid[d] = noise ? 1'($urandom) : 1'b1;
      in_data[d]  = noise ? 8'($urandom) : b;
      step();
    end
    chk($sformatf("send_timeout%0d", d), 64'd0, 64'd1);
  endtask

  task automatic idle(int d);
    in_valid[d] = 1'b0;
    in_data[d]  = 8'($urandom);
  endtask

  task automatic drain(int d);
    for (int n = 0; n < 300; n++) begin
      if (in_ready[d] && !busy[d]) return;
      step();
    end
    chk($sformatf("drain_timeout%0d", d), 64'd0, 64'd1);
  endtask

  initial begin
    int n0, l0, n_other;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0;
      in_data[d]  = 8'h00;
    end
    repeat (3) step();
    #2 rst = 1'b0;
    step();

    // 0xA5, one clock per bit, LSB first
    n0 = cap_n[0]; l0 = cap_l[0];
    send(0, 8'hA5, 1'b0); idle(0); drain(0);
    chk("a5_cnt", 64'(cap_n[0] - n0), 64'd8);
    chk("a5_bits", 64'(cap_bits[0][7:0]), 64'b10100101);
    chk("a5_last", 64'(cap_l[0] - l0), 64'd1);

    // 0x01, three clocks per bit
    n0 = cap_n[1];
    send(1, 8'h01, 1'b0); idle(1); drain(1);
    chk("x01_cnt", 64'(cap_n[1] - n0), 64'd24);
    chk("x01_bits", 64'(cap_bits[1][23:0]), 64'hE00000);

    // back-to-back 0x0F, 0xF0 with in_valid held
    n0 = cap_n[0]; l0 = cap_l[0];
    send(0, 8'h0F, 1'b0); send(0, 8'hF0, 1'b0); idle(0); drain(0);
    chk("b2b_cnt", 64'(cap_n[0] - n0), 64'd16);
    chk("b2b_bits", 64'(cap_bits[0][15:0]), 64'b1111000000001111);
    chk("b2b_last", 64'(cap_l[0] - l0), 64'd2);

    // 0xFF offered throughout 0x3C; taken only at the final-bit boundary
    n0 = cap_n[1];
    send(1, 8'h3C, 1'b0); send(1, 8'hFF, 1'b0); idle(1); drain(1);
    chk("hold_cnt", 64'(cap_n[1] - n0), 64'd48);
    chk("hold_bits", 64'(cap_bits[1][47:0]), 64'h03FFC0FFFFFF);

    // MSB first
    n0 = cap_n[2]; l0 = cap_l[2];
    send(2, 8'h80, 1'b0); idle(2); drain(2);
    chk("msb_cnt", 64'(cap_n[2] - n0), 64'd8);
    chk("msb_bits", 64'(cap_bits[2][7:0]), 64'h80);
    chk("msb_last", 64'(cap_l[2] - l0), 64'd1);

    // async reset during bit 4 of 0xAA (edges N+12..N+15 for three clocks per bit)
    send(1, 8'hAA, 1'b0); idle(1);
    repeat (12) step();
    chk("pre_rst_busy", {62'd0, ser_valid[1], busy[1]}, 64'd3);
    #2 rst = 1'b1;
    #1 chk("async_rst", {60'd0, ser_out[1], ser_valid[1], busy[1], in_ready[1]}, 64'd0);
    n_other = cap_n[0];
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h77;
    step(); step();
    idle(0);
    #2 rst = 1'b0;
    step();
    n0 = cap_n[1];
    send(1, 8'h55, 1'b0); idle(1); drain(1);
    chk("post_rst_cnt", 64'(cap_n[1] - n0), 64'd24);
    chk("post_rst_bits", 64'(cap_bits[1][23:0]), 64'hE38E38);
    chk("rst_no_capture", 64'(cap_n[0] - n_other), 64'd0);

    // randomized streams with noise while not ready and random gaps
    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j < 30; j++) begin
        send(d, 8'($urandom), 1'b1);
        if ($urandom_range(0, 1) == 0) begin
          idle(d);
          repeat ($urandom_range(0, 4)) step();
        end
      end
      idle(d);
      drain(d);
      step();
      chk($sformatf("queue_empty%0d", d), 64'(expq[d].size()), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
